sprite_cmd_scheduler: RTL and testbench

- Sits between the Avalon-MM CPU slave and the sprite display blocks (mushroom and sibling sprite renderers) that share one 32-bit command bus.
- Queues CPU sprite-update commands in a FIFO and forces their buffer-select bit to the current back buffer.
- Issues the buffer-flip (flush) command only at the start of vertical blanking, so the front buffer never changes mid-frame.
- Outputs an idle word (all zeros, control code 0) whenever it has nothing to issue.

---
 rtl/sprite_pkg.sv | 56 +++++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/sprite_cmd_scheduler.sv | 144 ++++++++++++++
 tb/tb_sprite_cmd_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command scheduler: command word layout,
// control codes, register map, FSM states and FIFO entry format.
package sprite_pkg;

  localparam int CMD_W      = 32;
  localparam int COMP_LSB   = 26;
  localparam int COMP_W     = 6;
  localparam int CHILD_LSB  = 21;
  localparam int CHILD_W    = 5;
  localparam int CTRL_LSB   = 17;
  localparam int CTRL_W     = 4;
  localparam int DTYPE_LSB  = 14;
  localparam int DTYPE_W    = 3;
  localparam int BUFSEL_BIT = 13;
  localparam int PAYLOAD_W  = 13;

  localparam logic [CTRL_W-1:0] CTRL_UPDATE = 4'h1;
  localparam logic [CTRL_W-1:0] CTRL_FLIP   = 4'hF;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_COMMIT = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VBL,
    ST_FLIP
  } sched_state_e;

  typedef struct packed {
    logic             marker;
    logic [CMD_W-1:0] word;
  } fifo_entry_t;

  function automatic logic [CMD_W-1:0] make_cmd(
    input logic [COMP_W-1:0]    comp,
    input logic [CHILD_W-1:0]   child,
    input logic [CTRL_W-1:0]    ctrl,
    input logic [DTYPE_W-1:0]   dtype,
    input logic                 bufsel,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [CMD_W-1:0] w;
    w                         = '0;
    w[COMP_LSB +: COMP_W]     = comp;
    w[CHILD_LSB +: CHILD_W]   = child;
    w[CTRL_LSB +: CTRL_W]     = ctrl;
    w[DTYPE_LSB +: DTYPE_W]   = dtype;
    w[BUFSEL_BIT]             = bufsel;
    w[PAYLOAD_W-1:0]          = payload;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of command entries; pushes while
// full and pops while empty are ignored.
module cmd_fifo
  import sprite_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  fifo_entry_t             din,
  output fifo_entry_t             head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  fifo_entry_t      mem_q [DEPTH];
  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == LVL_W'(DEPTH));
    empty    = (level == '0);
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + LVL_W'(push_ok);
    rd_ptr_d = rd_ptr_q + LVL_W'(pop_ok);
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Queues CPU sprite commands onto the shared display command bus and releases
// buffer flips only at the start of vertical blanking.
module sprite_cmd_scheduler
  import sprite_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480,
  parameter logic [9:0] FLIP_HCOUNT = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf
);

  // state     | meaning
  // IDLE      | nothing to issue
  // ISSUE     | update word on cmd_out this cycle
  // WAIT_VBL  | commit marker at head, holding until vblank
  // FLIP      | flip word on cmd_out this cycle

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_e     state_q, state_d;
  logic [31:0]      cmd_q, cmd_d;
  logic             front_buf_q, front_buf_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             flipped_q, flipped_d;
  logic             ovf_q, ovf_d;

  fifo_entry_t      push_entry, head;
  logic             push, pop, full, empty;
  logic [LVL_W-1:0] level;
  logic             ovf_clr, vbl_hit, flip_now;
  logic             unused_read;

  assign unused_read = read;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    ovf_clr    = 1'b0;
    if (chipselect && write) begin
      case (address)
        ADDR_CMD: begin
          push            = 1'b1;
          push_entry.word = writedata;
        end
        ADDR_COMMIT: begin
          push              = 1'b1;
          push_entry.marker = 1'b1;
        end
        ADDR_STATUS: ovf_clr = writedata[0];
        ADDR_RSVD:   ;
      endcase
    end
  end

  assign vbl_hit = (vcount == VBLANK_LINE) && (hcount == FLIP_HCOUNT) && !flipped_q;

  // ISSUE and FLIP fall through to the IDLE rules so words can stream back-to-back.
  always_comb begin
    state_d     = state_q;
    cmd_d       = '0;
    pop         = 1'b0;
    front_buf_d = front_buf_q;
    frame_cnt_d = frame_cnt_q;
    flip_now    = 1'b0;
    case (state_q)
      ST_WAIT_VBL: begin
        if (vbl_hit) begin
          state_d     = ST_FLIP;
          cmd_d       = make_cmd('0, '0, CTRL_FLIP, '0, ~front_buf_q, '0);
          pop         = 1'b1;
          front_buf_d = ~front_buf_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          flip_now    = 1'b1;
        end
      end
      default: begin
        if (empty) begin
          state_d = ST_IDLE;
        end else if (head.marker) begin
          state_d = ST_WAIT_VBL;
        end else begin
          state_d           = ST_ISSUE;
          cmd_d             = head.word;
          cmd_d[BUFSEL_BIT] = ~front_buf_q;
          pop               = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    flipped_d = (vcount != VBLANK_LINE) ? 1'b0 : (flipped_q | flip_now);
    ovf_d     = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      front_buf_q <= 1'b0;
      frame_cnt_q <= '0;
      flipped_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      front_buf_q <= front_buf_d;
      frame_cnt_q <= frame_cnt_d;
      flipped_q   <= flipped_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cmd_out   = cmd_q;
  assign front_buf = front_buf_q;
  assign readdata  = {frame_cnt_q, 7'b0, ovf_q, front_buf_q, 7'(level)};

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Bench for sprite_cmd_scheduler: directed scenarios plus random traffic, all
// checked against a queue-based reference of the scheduling rules.
module tb_sprite_cmd_scheduler;
  import sprite_pkg::*;

  localparam int         DEPTH = 16;
  localparam logic [9:0] VBL   = 10'd480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [9:0]  hcount = '0, vcount = '0;
  logic [31:0] cmd_out;
  logic        front_buf;

  sprite_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .VBLANK_LINE(VBL), .FLIP_HCOUNT(10'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .cmd_out    (cmd_out),
    .front_buf  (front_buf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_flip = 0;

  // reference state: pending entries {marker, word}, plus visible status
  logic [32:0] mq[$];
  logic [31:0] m_cmd;
  logic        m_fb, m_ovf, m_fl, m_armed;
  logic [15:0] m_fc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {m_fc, 7'b0, m_ovf, m_fb, 7'(mq.size())};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cmd = '0; m_fb = 1'b0; m_ovf = 1'b0; m_fl = 1'b0; m_armed = 1'b0; m_fc = '0;
  endtask

  // One clock of the scheduling rules: decide on what is already queued,
  // then accept this cycle's write (so a new word is visible a cycle later).
  task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] d,
                            input logic [9:0] hc, input logic [9:0] vc);
    logic        was_full, did_flip;
    logic [31:0] w;
    was_full = (mq.size() == DEPTH);
    did_flip = 1'b0;
    m_cmd    = '0;
    if (mq.size() > 0) begin
      if (!mq[0][32]) begin
        w      = mq[0][31:0];
        w[13]  = ~m_fb;
        m_cmd  = w;
        void'(mq.pop_front());
        m_armed = 1'b0;
      end else if (m_armed && vc == VBL && hc == 10'd0 && !m_fl) begin
        m_cmd   = {11'b0, 4'hF, 3'b0, ~m_fb, 13'b0};
        m_fb    = ~m_fb;
        m_fc    = m_fc + 16'd1;
        did_flip = 1'b1;
        void'(mq.pop_front());
        m_armed = 1'b0;
      end else begin
        m_armed = 1'b1;
      end
    end
    if (vc != VBL) m_fl = 1'b0;
    else if (did_flip) m_fl = 1'b1;
    if (wr) begin
      if (a == 2'd0 || a == 2'd1) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back((a == 2'd1) ? {1'b1, 32'h0} : {1'b0, d});
      end else if (a == 2'd2 && d[0]) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic cs, input logic we, input logic [1:0] a, input logic [31:0] d,
                       input logic [9:0] hc, input logic [9:0] vc);
    chipselect = cs; write = we; address = a; writedata = d;
    hcount = hc; vcount = vc; read = 1'($urandom_range(0, 1));
    model_step(cs & we, a, d, hc, vc);
    @(posedge clk);
    #1;
    chk_eq("cmd_out", cmd_out, m_cmd);
    chk_eq("status", readdata, m_status());
    chk_eq("front_buf", {31'b0, front_buf}, {31'b0, m_fb});
    if (cmd_out[CTRL_LSB +: 4] == CTRL_FLIP) n_flip++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [9:0] hc, input logic [9:0] vc);
    cycle(1'b1, 1'b1, a, d, hc, vc);
  endtask

  task automatic idle(input logic [9:0] hc, input logic [9:0] vc);
    cycle(1'b0, 1'b0, 2'd0, 32'h0, hc, vc);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    chipselect = 1'b0; write = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_eq("rst_cmd", cmd_out, 32'h0);
    chk_eq("rst_status", readdata, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [9:0]  hc, vc;
    int          r;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // single update: appears two cycles after the write, then idles
    wr(2'd0, 32'h24220803, 10'd5, 10'd100);
    chk_eq("lat_t1", cmd_out, 32'h0);
    idle(10'd6, 10'd100);
    chk_eq("lat_t2", cmd_out, 32'h24222803);
    idle(10'd7, 10'd100);
    chk_eq("lat_t3", cmd_out, 32'h0);
    chk_eq("lvl0", {25'b0, readdata[6:0]}, 32'h0);

    // three back-to-back updates stream at one per cycle
    wr(2'd0, 32'h24220001, 10'd1, 10'd100);
    wr(2'd0, 32'h04021FFF, 10'd2, 10'd100);
    chk_eq("b2b_0", cmd_out, 32'h24222001);
    wr(2'd0, 32'h8C22D555, 10'd3, 10'd100);
    chk_eq("b2b_1", cmd_out, 32'h04023FFF);
    idle(10'd4, 10'd100);
    chk_eq("b2b_2", cmd_out, 32'h8C22F555);
    idle(10'd5, 10'd100);

    // commit holds the trailing update until the flip at vblank
    wr(2'd0, 32'h24220011, 10'd1, 10'd100);
    wr(2'd0, 32'h24220022, 10'd2, 10'd100);
    wr(2'd1, 32'h0, 10'd3, 10'd100);
    wr(2'd0, 32'h24222033, 10'd4, 10'd100);
    for (int i = 0; i < 4; i++) idle(10'd0, 10'd100);
    chk_eq("held_lvl", {25'b0, readdata[6:0]}, 32'd2);
    chk_eq("held_cmd", cmd_out, 32'h0);
    idle(10'd0, VBL);
    chk_eq("flip_word", cmd_out, 32'h001E2000);
    chk_eq("flip_fb", {31'b0, front_buf}, 32'd1);
    chk_eq("flip_fc", {16'b0, readdata[31:16]}, 32'd1);
    idle(10'd1, VBL);
    chk_eq("after_flip", cmd_out, 32'h24220033);

    // one flip per frame even with hcount held at the match value
    do_reset();
    wr(2'd1, 32'h0, 10'd5, 10'd100);
    wr(2'd1, 32'h0, 10'd5, 10'd100);
    for (int i = 0; i < 3; i++) idle(10'd0, 10'd100);
    n_flip = 0;
    for (int i = 0; i < 4; i++) idle(10'd0, VBL);
    for (int h = 1; h < 4; h++) idle(10'(h), VBL);
    chk_eq("one_flip", 32'(n_flip), 32'd1);
    idle(10'd0, 10'd481);
    idle(10'd0, 10'd479);
    chk_eq("no_early_flip", 32'(n_flip), 32'd1);
    idle(10'd0, VBL);
    chk_eq("second_flip", 32'(n_flip), 32'd2);
    chk_eq("fc_two", {16'b0, readdata[31:16]}, 32'd2);

    // overflow while stalled behind a marker, then clear
    do_reset();
    wr(2'd1, 32'h0, 10'd5, 10'd100);
    for (int i = 0; i < 17; i++) wr(2'd0, 32'($urandom), 10'd5, 10'd100);
    idle(10'd5, 10'd100);
    chk_eq("ovf_set", {31'b0, readdata[8]}, 32'd1);
    chk_eq("ovf_lvl", {25'b0, readdata[6:0]}, 32'd16);
    wr(2'd2, 32'h1, 10'd5, 10'd100);
    chk_eq("ovf_clr", {31'b0, readdata[8]}, 32'd0);

    // reset while waiting for vblank discards the queue and the pending flip
    do_reset();
    wr(2'd1, 32'h0, 10'd5, 10'd100);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h24220100 + 32'(i), 10'd5, 10'd100);
    idle(10'd5, 10'd100);
    idle(10'd5, 10'd100);
    chk_eq("pre_rst_lvl", {25'b0, readdata[6:0]}, 32'd5);
    do_reset();
    idle(10'd0, 10'd479);
    for (int i = 0; i < 3; i++) begin
      idle(10'd0, VBL);
      chk_eq("rst_quiet", cmd_out, 32'h0);
    end
    chk_eq("rst_lvl", {25'b0, readdata[6:0]}, 32'd0);
    chk_eq("rst_fb", {31'b0, front_buf}, 32'd0);

    // random traffic over a compressed raster around the vblank line
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      vc = 10'(476 + (c / 6) % 8);
      hc = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 700));
      w  = $urandom;
      if ($urandom_range(0, 1) == 1) w[CTRL_LSB +: 4] = CTRL_UPDATE;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 999) == 0) do_reset();
      else if (r < 45) cycle(($urandom_range(0, 7) != 0), 1'b1, 2'd0, w, hc, vc);
      else if (r < 52) wr(2'd1, w, hc, vc);
      else if (r < 55) wr(2'd2, w, hc, vc);
      else if (r < 57) wr(2'd3, w, hc, vc);
      else idle(hc, vc);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
